// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - hazard/stall controller for the 5-stage pipeline
module pipe_stall_ctrl #(
    parameter int CNT_W  = 6,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_use_i,
    input  logic              md_start_i,
    input  logic [CNT_W-1:0]  md_cycles_i,
    input  logic              mem_busy_i,
    input  logic              br_taken_i,
    output logic [5:0]        stall_o,
    output logic              flush_o,
    output logic              md_busy_o,
    output logic              md_done_o,
    output logic [PERF_W-1:0] stall_cnt_o
);

    typedef enum logic {
        S_RUN = 1'b0,
        S_MD  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [PERF_W-1:0] stall_cnt;

    logic              md_accept;
    logic              md_last;
    logic              md_req;
    logic [5:0]        stall;
    logic              flush;

    // Stall priority: MEM wait > multi-cycle EX > load-use; a taken branch
    // only flushes when EX is free to advance, and then suppresses load-use.
    always_comb begin
        md_accept = (state == S_RUN) && md_start_i && !mem_busy_i;
        md_last   = (state == S_MD) && (cnt <= CNT_ONE);
        md_req    = md_accept || ((state == S_MD) && (cnt > CNT_ONE));
        stall     = 6'b000000;
        flush     = 1'b0;
        if (!rst) begin
            if (mem_busy_i) begin
                stall = 6'b011111;
            end else if (md_req) begin
                stall = 6'b001111;
            end
            flush = br_taken_i & ~stall[3];
            if ((stall == 6'b000000) && ld_use_i && !flush) begin
                stall = 6'b000111;
            end
        end
    end

    // Multi-cycle EX sequencer: load the length on issue, count down to done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (md_accept) begin
                        cnt   <= (md_cycles_i == '0) ? CNT_ONE : md_cycles_i;
                        state <= S_MD;
                    end
                end
                S_MD: begin
                    if (md_last) begin
                        cnt   <= '0;
                        state <= S_RUN;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    state <= S_RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall[0] && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + PERF_ONE;
        end
    end

    assign stall_o     = stall;
    assign flush_o     = flush;
    assign md_busy_o   = !rst && (state == S_MD);
    assign md_done_o   = !rst && md_last;
    assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - scoreboard bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        ld_use_i;
    logic        md_start_i;
    logic [5:0]  md_cycles_i;
    logic        mem_busy_i;
    logic        br_taken_i;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic        md_busy_o;
    logic        md_done_o;
    logic [31:0] stall_cnt_o;

    logic [5:0]  s_stall_o;
    logic        s_flush_o;
    logic        s_md_busy_o;
    logic        s_md_done_o;
    logic [2:0]  s_stall_cnt_o;

    pipe_stall_ctrl #(.CNT_W(6), .PERF_W(32)) dut (
        .clk(clk), .rst(rst), .ld_use_i(ld_use_i), .md_start_i(md_start_i),
        .md_cycles_i(md_cycles_i), .mem_busy_i(mem_busy_i), .br_taken_i(br_taken_i),
        .stall_o(stall_o), .flush_o(flush_o), .md_busy_o(md_busy_o),
        .md_done_o(md_done_o), .stall_cnt_o(stall_cnt_o)
    );

    // Narrow counter copy so saturation is reachable in a short run.
    pipe_stall_ctrl #(.CNT_W(6), .PERF_W(3)) dut_sat (
        .clk(clk), .rst(rst), .ld_use_i(ld_use_i), .md_start_i(md_start_i),
        .md_cycles_i(md_cycles_i), .mem_busy_i(mem_busy_i), .br_taken_i(br_taken_i),
        .stall_o(s_stall_o), .flush_o(s_flush_o), .md_busy_o(s_md_busy_o),
        .md_done_o(s_md_done_o), .stall_cnt_o(s_stall_cnt_o)
    );

    typedef struct {
        int         idx;
        logic [5:0] stall;
        logic       flush;
        logic       busy;
        logic       done;
        logic       chk_cnt;
        int         cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_n  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, req);
        end
    endtask

    // Apply one cycle of inputs and queue the response expected in that cycle.
    task automatic v(input logic r, input logic ld, input logic mds, input int mdc,
                     input logic mem, input logic br, input logic [5:0] st,
                     input logic fl, input logic bu, input logic dn,
                     input logic cc, input int cn);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = r;
        ld_use_i    = ld;
        md_start_i  = mds;
        md_cycles_i = mdc[5:0];
        mem_busy_i  = mem;
        br_taken_i  = br;
        e.idx = vec_n; e.stall = st; e.flush = fl; e.busy = bu; e.done = dn;
        e.chk_cnt = cc; e.cnt = cn;
        exp_q.push_back(e);
        vec_n++;
    endtask

    // Monitor: compare every DUT output against the queued expectation.
    initial begin
        exp_t e;
        int   sat;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stall_o", e.idx, stall_o, e.stall);
                chk("flush_o", e.idx, flush_o, e.flush);
                chk("md_busy_o", e.idx, md_busy_o, e.busy);
                chk("md_done_o", e.idx, md_done_o, e.done);
                chk("stall_prefix", e.idx, ((stall_o & (stall_o + 6'd1)) == 6'd0), 1);
                if (e.chk_cnt) begin
                    sat = (e.cnt > 7) ? 7 : e.cnt;
                    chk("stall_cnt_o", e.idx, stall_cnt_o, e.cnt);
                    chk("stall_cnt_sat", e.idx, s_stall_cnt_o, sat);
                end
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b1; ld_use_i = 1'b0; md_start_i = 1'b0; md_cycles_i = 6'd0;
        mem_busy_i = 1'b0; br_taken_i = 1'b0;

        // reset with all inputs high
        v(1,1,1,63,1,1, 6'b000000,0,0,0, 0,0);
        v(1,1,1,63,1,1, 6'b000000,0,0,0, 1,0);
        v(1,1,1,63,1,1, 6'b000000,0,0,0, 1,0);
        // idle
        v(0,0,0,0,0,0, 6'b000000,0,0,0, 1,0);
        v(0,0,0,0,0,0, 6'b000000,0,0,0, 1,0);
        // load-use single cycle
        v(0,1,0,0,0,0, 6'b000111,0,0,0, 1,0);
        v(0,0,0,0,0,0, 6'b000000,0,0,0, 1,1);
        // multi-cycle op N=4
        v(0,0,1,4,0,0, 6'b001111,0,0,0, 1,1);
        v(0,0,0,0,0,0, 6'b001111,0,1,0, 1,2);
        v(0,0,0,0,0,0, 6'b001111,0,1,0, 1,3);
        v(0,0,0,0,0,0, 6'b001111,0,1,0, 1,4);
        v(0,0,0,0,0,0, 6'b000000,0,1,1, 1,5);
        v(0,0,0,0,0,0, 6'b000000,0,0,0, 1,5);
        // overlap N=3 with mem_busy t+1..t+4, start at t+2 ignored
        v(0,0,1,3,0,0, 6'b001111,0,0,0, 1,5);
        v(0,0,0,0,1,0, 6'b011111,0,1,0, 1,6);
        v(0,0,1,7,1,0, 6'b011111,0,1,0, 1,7);
        v(0,0,0,0,1,0, 6'b011111,0,1,1, 1,8);
        v(0,0,0,0,1,0, 6'b011111,0,0,0, 1,9);
        v(0,0,0,0,0,0, 6'b000000,0,0,0, 1,10);
        // length 0 treated as 1
        v(0,0,1,0,0,0, 6'b001111,0,0,0, 1,10);
        v(0,0,0,0,0,0, 6'b000000,0,1,1, 1,11);
        v(0,0,0,0,0,0, 6'b000000,0,0,0, 1,11);
        // branch together with load-use: flush wins
        v(0,1,0,0,0,1, 6'b000000,1,0,0, 1,11);
        v(0,0,0,0,0,0, 6'b000000,0,0,0, 1,11);
        // branch held during N=2 op
        v(0,0,1,2,0,1, 6'b001111,0,0,0, 1,11);
        v(0,0,0,0,0,1, 6'b001111,0,1,0, 1,12);
        v(0,0,0,0,0,1, 6'b000000,1,1,1, 1,13);
        v(0,0,0,0,0,0, 6'b000000,0,0,0, 1,13);
        // start while memory busy is not accepted
        v(0,0,1,5,1,0, 6'b011111,0,0,0, 1,13);
        v(0,0,0,0,0,0, 6'b000000,0,0,0, 1,14);
        // reset in the 3rd S_MD cycle of an N=10 op
        v(0,0,1,10,0,0, 6'b001111,0,0,0, 1,14);
        v(0,0,0,0,0,0, 6'b001111,0,1,0, 1,15);
        v(0,0,0,0,0,0, 6'b001111,0,1,0, 1,16);
        v(1,0,0,0,0,0, 6'b000000,0,0,0, 0,0);
        v(0,0,0,0,0,0, 6'b000000,0,0,0, 1,0);
        v(0,0,0,0,0,0, 6'b000000,0,0,0, 1,0);
        // long load-use stall: narrow counter saturates and holds
        for (int i = 0; i < 10; i++) begin
            v(0,1,0,0,0,0, 6'b000111,0,0,0, 1,i);
        end
        v(0,0,0,0,0,0, 6'b000000,0,0,0, 1,10);
        v(0,0,0,0,0,0, 6'b000000,0,0,0, 1,10);

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
